// File: rtl/router_port_feeder.sv
// Per-port byte FIFO feeding one router input through a request/ready handshake.
// Optional head-byte drop on stalled request is built when FEEDER_TIMEOUT_EN is defined.
module router_port_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     request,
  output logic [7:0]               inData,
  input  logic                     ready,
  output logic                     timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [DEPTH];
  logic           request_q, request_d;
  logic [7:0]     in_data_q, in_data_d;
  logic           overflow_q, overflow_d;
  logic           timeout_err_q, timeout_err_d;
  logic           full_c, empty_c, push_c, pop_c, timeout_hit_c;
  logic [15:0]    wait_q, wait_d;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign push_c  = wr_en && !full_c;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push_c);
    rd_ptr_d   = rd_ptr_q + PW'(pop_c);
    overflow_d = wr_en && full_c;
  end

  // Next-state logic; pop happens only from REQ, which implies a valid head.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pop_c         = 1'b0;
    timeout_hit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          state_d = ST_REQ;
          wait_d  = 16'd0;
        end
      end
      ST_REQ: begin
        if (ready) begin
          pop_c   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
`ifdef FEEDER_TIMEOUT_EN
          if (wait_q + 16'd1 == TIMEOUT_CNT) begin
            pop_c         = 1'b1;
            timeout_hit_c = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            wait_d = wait_q + 16'd1;
          end
`endif
        end
      end
      ST_RELEASE: begin
        if (!ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: inData loads only on the IDLE->REQ transition.
  always_comb begin
    request_d     = (state_d == ST_REQ);
    in_data_d     = in_data_q;
    timeout_err_d = timeout_hit_c;
    if (state_q == ST_IDLE && state_d == ST_REQ) in_data_d = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      request_q     <= 1'b0;
      in_data_q     <= 8'h00;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      request_q     <= request_d;
      in_data_q     <= in_data_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= 16'd0;
    else      wait_q <= wait_d;
  end
`else
  // Without the drop path there is no wait counter and TIMEOUT is irrelevant.
  logic unused_timeout_c;
  assign wait_q           = 16'd0;
  assign unused_timeout_c = ^{TIMEOUT_CNT, wait_d};
`endif

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign full        = full_c;
  assign empty       = empty_c;
  assign count       = wr_ptr_q - rd_ptr_q;
  assign overflow    = overflow_q;
  assign request     = request_q;
  assign inData      = in_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_router_port_feeder.sv
// Directed bench for router_port_feeder: table-driven handshake vectors plus
// hand-written reset, full/overflow, concurrent push/pop and timeout sequences.
module tb_router_port_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, request, timeout_err;
  logic [3:0] count;
  logic [7:0] inData;

  logic       t_wr_en = 1'b0, t_ready = 1'b0;
  logic [7:0] t_wr_data = 8'h00;
  logic       t_full, t_empty, t_overflow, t_request, t_timeout_err;
  logic [3:0] t_count;
  logic [7:0] t_inData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_port_feeder #(.DEPTH(8), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .request(request),
    .inData(inData), .ready(ready), .timeout_err(timeout_err));

  router_port_feeder #(.DEPTH(8), .TIMEOUT(5)) dut_to (
    .clk(clk), .rst(rst), .wr_en(t_wr_en), .wr_data(t_wr_data), .full(t_full),
    .empty(t_empty), .count(t_count), .overflow(t_overflow), .request(t_request),
    .inData(t_inData), .ready(t_ready), .timeout_err(t_timeout_err));

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready;
    logic       exp_req;
    logic [7:0] exp_data;
    logic [3:0] exp_count;
    logic       exp_empty;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check the byte, acknowledge it and release.
  task automatic ack_byte(input logic [7:0] exp, input logic do_wr,
                          input logic [7:0] wd, input int exp_cnt);
    int n;
    n = 0;
    while (!request && n < 12) begin
      step();
      n++;
    end
    chk("ack_wait_req", 32'(request), 1);
    chk("ack_data", 32'(inData), 32'(exp));
    ready = 1'b1; wr_en = do_wr; wr_data = wd;
    step();
    chk("ack_req_drop", 32'(request), 0);
    chk("ack_count", 32'(count), exp_cnt);
    ready = 1'b0; wr_en = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single byte with stalled ready, then release.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b1};
    // Held-high ready must not acknowledge the second byte.
    vecs[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'hA5, 4'd1, 1'b0};
    vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 4'd2, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 4'd1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 4'd1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 4'd1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 4'd0, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 4'd0, 1'b1};

    #1 rst = 1'b0;
    #2;
    chk("rst_request", 32'(request), 0);
    chk("rst_inData", 32'(inData), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    step(); step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_request", i), 32'(request), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_inData", i), 32'(inData), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
    end
    wr_en = 1'b0; ready = 1'b0;

    // Full / overflow: nine back-to-back writes with ready low.
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      step();
      if (i == 7) chk("full_before_8th", 32'(full), 0);
      if (i == 8) begin
        chk("full_after_8th", 32'(full), 1);
        chk("overflow_after_8th", 32'(overflow), 0);
      end
    end
    chk("overflow_pulse", 32'(overflow), 1);
    chk("overflow_count", 32'(count), 8);
    chk("overflow_full", 32'(full), 1);
    wr_en = 1'b0;
    step();
    chk("overflow_clear", 32'(overflow), 0);
    for (int i = 1; i <= 8; i++) ack_byte(8'(8'h30 + i), 1'b0, 8'h00, 8 - i);
    chk("drain_empty", 32'(empty), 1);

    // Concurrent push and pop at count 4, continuing across the pointer wrap.
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_en = 1'b0;
    chk("conc_count4", 32'(count), 4);
    for (int i = 1; i <= 5; i++) ack_byte(8'(8'h40 + i), 1'b1, 8'(8'h44 + i), 4);
    for (int i = 6; i <= 9; i++) ack_byte(8'(8'h40 + i), 1'b0, 8'h00, 9 - i);
    chk("conc_empty", 32'(empty), 1);

    // Reset mid-REQ with three bytes buffered.
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_rst_request", 32'(request), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_request", 32'(request), 0);
    chk("midrst_inData", 32'(inData), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_full", 32'(full), 0);
    #1 rst = 1'b1;
    step();
    chk("post_rst_request", 32'(request), 0);

    // Stalled request on the short-timeout instance.
    t_wr_en = 1'b1; t_wr_data = 8'h3C;
    step();
    t_wr_data = 8'h4D;
    step();
    t_wr_en = 1'b0;
    chk("to_req", 32'(t_request), 1);
    chk("to_data", 32'(t_inData), 32'h3C);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_err", 32'(t_timeout_err), 0);
      chk("to_wait_req", 32'(t_request), 1);
    end
    step();
`ifdef FEEDER_TIMEOUT_EN
    chk("to_pulse", 32'(t_timeout_err), 1);
    chk("to_req_drop", 32'(t_request), 0);
    chk("to_count", 32'(t_count), 1);
    step();
    chk("to_pulse_end", 32'(t_timeout_err), 0);
    chk("to_next_req", 32'(t_request), 1);
    chk("to_next_data", 32'(t_inData), 32'h4D);
`else
    chk("to_no_pulse", 32'(t_timeout_err), 0);
    chk("to_still_req", 32'(t_request), 1);
    chk("to_count", 32'(t_count), 2);
    step();
    chk("to_no_pulse2", 32'(t_timeout_err), 0);
    chk("to_held_req", 32'(t_request), 1);
    chk("to_held_data", 32'(t_inData), 32'h3C);
`endif
    chk("to_not_full", 32'(t_full), 0);
    chk("to_not_empty", 32'(t_empty), 0);
    chk("to_no_overflow", 32'(t_overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_feeder.md
# router_port_feeder

Per-port source stage sitting directly upstream of the 4-port router: one instance per input port. Buffers bytes written by the local producer in a small FIFO and drives the router's `inDataN`/`requestN` pair, popping one byte per completed `readyN` handshake. It decouples producer bursts from router arbitration latency and, optionally, drops bytes the router never services.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `TIMEOUT`, 255: cycles `request` may stay high without `ready` before the head byte is dropped (used only with `FEEDER_TIMEOUT_EN`); 1..65535.

- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  producer write strobe, one byte per cycle.
- `wr_data`  input  8  producer byte.
- `full`  output  1  FIFO holds `DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `count`  output  clog2(DEPTH)+1  bytes held.
- `overflow`  output  1  one-cycle pulse: write attempted while full.
- `request`  output  1  to router `requestN`.
- `inData`  output  8  to router `inDataN`.
- `ready`  input  1  from router `readyN`; level, acknowledges the presented byte.
- `timeout_err`  output  1  one-cycle pulse: head byte dropped on timeout.

## Operation
- FIFO: circular buffer, read/write pointers with one extra wrap bit; `full`/`empty` from pointer compare; `count` = wr_ptr − rd_ptr.
- Write: accepted when `wr_en` && !`full` (full evaluated before any same-cycle pop). Write while full is discarded and pulses `overflow`; FIFO unchanged.
- Simultaneous write and pop with 0 < count < DEPTH: both occur, `count` unchanged.
- FSM states IDLE, REQ, RELEASE:
  - IDLE: `request`=0. If !`empty` → REQ; `inData` loads head byte on this transition.
  - REQ: `request`=1, `inData` held stable. If `ready`=1 → pop head, go RELEASE. Else (timeout build) increment wait counter; at `TIMEOUT` → pop head, pulse `timeout_err`, go IDLE.
  - RELEASE: `request`=0; stay until `ready`=0, then IDLE. Prevents a held-high `ready` from acknowledging the next byte.
- Wait counter clears on entry to REQ.
- `inData` changes only on IDLE→REQ; otherwise holds last value.

## Timing
- Reset (rst=0, asynchronous): pointers 0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `request`=0, `inData`=8'h00, `timeout_err`=0, state IDLE, wait counter 0.
- Reset asserted mid-handshake: `request` drops immediately; buffered bytes are lost.
- Write to empty FIFO at edge N: `count`=1 after N; `request`=1 and `inData`=byte after N+1.
- `ready` sampled high at edge M while in REQ: `request`=0 and `count` decremented after M.
- Minimum per-byte period: 3 cycles (IDLE, REQ with immediate `ready`, RELEASE with `ready` already low at next edge).
- All outputs registered; no combinational path from `ready` or `wr_en` to any output.

## Configuration
- `FEEDER_TIMEOUT_EN` defined: wait counter (16 bits) and drop path built as above.
- Undefined: no counter; REQ waits for `ready` indefinitely; `timeout_err` tied 0; `TIMEOUT` ignored.

## Test plan
- Reset: write 3 bytes, pulse rst low mid-REQ → all outputs at reset values within the same cycle, `empty`=1.
- Single byte: write 8'hA5, hold `ready`=0 for 4 cycles, then 1 → `request`=1 two edges after write, `inData`=8'hA5 stable throughout, `request`=0 and `empty`=1 one edge after `ready`.
- Held ready: write 8'h11, 8'h22, keep `ready`=1 continuously → 8'h11 popped, state stays RELEASE, 8'h22 not presented until `ready`=0; then `inData`=8'h22.
- Full/overflow: DEPTH=8, write 9 bytes back-to-back with `ready`=0 → `full`=1 after 8th, 9th pulses `overflow`, `count`=8; drain yields bytes 1..8 in order.
- Concurrent: count=4, write on the same edge `ready` acknowledges → `count` stays 4, order preserved across pointer wrap.
- Timeout (`FEEDER_TIMEOUT_EN`, TIMEOUT=5): write 8'h3C, 8'h4D, `ready`=0 → `timeout_err` pulses after 5 REQ cycles, 8'h3C dropped, 8'h4D presented next.
